// File: rtl/lbm_step_sequencer.sv
// LBM time-step sequencer: INIT sweep, then n_steps x (MOMENT, COLLIDE, STREAM) pipelined sweeps.
// Optional `LBM_STALL_EN adds a stall input that freezes the sequencer and masks all write strobes.
module lbm_step_sequencer #(
   parameter int unsigned GRID_DIM      = 256,
   parameter int unsigned ADDRESS_WIDTH = $clog2(GRID_DIM),
   parameter int unsigned RD_LAT        = 1,
   parameter int unsigned STEP_W        = 16
) (
   input  logic                     Clk,
   input  logic                     Reset,
`ifdef LBM_STALL_EN
   input  logic                     stall,
`endif
   input  logic                     start,
   input  logic [STEP_W-1:0]        n_steps,
   output logic                     busy,
   output logic                     done,
   output logic [2:0]               phase,
   output logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic [ADDRESS_WIDTH-1:0] wr_addr,
   output logic                     WE_p_mem,
   output logic                     WE_ux_mem,
   output logic                     WE_uy_mem,
   output logic                     WE_fin_mem,
   output logic                     WE_fout_mem,
   output logic                     WE_feq_mem,
   output logic                     select_fin,
   output logic                     LD_EN_P,
   output logic [STEP_W-1:0]        step_count
);

   localparam int unsigned PIPE       = RD_LAT + 1;
   localparam int unsigned LAST_ADDR  = GRID_DIM - 1;
   localparam int unsigned LAST_SWEEP = GRID_DIM + PIPE - 1;
   localparam int unsigned CNT_W      = $clog2(GRID_DIM + PIPE);

   // Write-enable vector bit order: {feq, fout, fin, uy, ux, p}
   localparam logic [5:0] WE_INIT    = 6'b001111;
   localparam logic [5:0] WE_MOMENT  = 6'b000111;
   localparam logic [5:0] WE_COLLIDE = 6'b110000;
   localparam logic [5:0] WE_STREAM  = 6'b001000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      MOMENT  = 3'd2,
      COLLIDE = 3'd3,
      STREAM  = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic                     iss;
   logic [STEP_W-1:0]        n_lat;
   logic [5:0]               we_q;
   logic [5:0]               we_pipe   [PIPE-1];
   logic [ADDRESS_WIDTH-1:0] addr_pipe [PIPE-1];
   logic [RD_LAT-1:0]        ld_sr;
   logic                     hold;

`ifdef LBM_STALL_EN
   assign hold = stall;
`else
   assign hold = 1'b0;
`endif

   function automatic logic [5:0] sweep_we(input state_t s);
      case (s)
         MOMENT:  sweep_we = WE_MOMENT;
         COLLIDE: sweep_we = WE_COLLIDE;
         STREAM:  sweep_we = WE_STREAM;
         default: sweep_we = 6'b000000;
      endcase
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         iss        <= 1'b0;
         n_lat      <= '0;
         step_count <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         select_fin <= 1'b0;
         rd_addr    <= '0;
         wr_addr    <= '0;
         we_q       <= '0;
         ld_sr      <= '0;
         for (int i = 0; i < int'(PIPE) - 1; i++) begin
            we_pipe[i]   <= '0;
            addr_pipe[i] <= '0;
         end
      end else if (!hold) begin
         // Read-to-write delay line; INIT overrides the write side below
         we_pipe[0]   <= iss ? sweep_we(state) : 6'b000000;
         addr_pipe[0] <= rd_addr;
         for (int i = 1; i < int'(PIPE) - 1; i++) begin
            we_pipe[i]   <= we_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
         end
         we_q    <= we_pipe[PIPE-2];
         wr_addr <= addr_pipe[PIPE-2];
         ld_sr   <= RD_LAT'({ld_sr, iss && (state == MOMENT)});

         case (state)
            IDLE: begin
               if (start) begin
                  state      <= INIT;
                  cnt        <= '0;
                  n_lat      <= n_steps;
                  step_count <= '0;
                  busy       <= 1'b1;
                  rd_addr    <= '0;
                  wr_addr    <= '0;
                  we_q       <= WE_INIT;
                  select_fin <= 1'b0;
               end
            end
            INIT: begin
               if (cnt != CNT_W'(LAST_ADDR)) begin
                  cnt     <= cnt + 1'b1;
                  rd_addr <= rd_addr + 1'b1;
                  wr_addr <= rd_addr + 1'b1;
                  we_q    <= WE_INIT;
               end else begin
                  cnt     <= '0;
                  rd_addr <= '0;
                  if (n_lat != '0) begin
                     state <= MOMENT;
                     iss   <= 1'b1;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            MOMENT, COLLIDE, STREAM: begin
               if (cnt != CNT_W'(LAST_SWEEP)) begin
                  cnt <= cnt + 1'b1;
                  if (cnt < CNT_W'(LAST_ADDR)) rd_addr <= rd_addr + 1'b1;
                  else                         iss     <= 1'b0;
               end else begin
                  // Phase boundary: the only place the address wraps
                  cnt     <= '0;
                  rd_addr <= '0;
                  iss     <= 1'b1;
                  if (state == MOMENT) begin
                     state <= COLLIDE;
                  end else if (state == COLLIDE) begin
                     state      <= STREAM;
                     select_fin <= 1'b1;
                  end else begin
                     select_fin <= 1'b0;
                     if (step_count != '1) step_count <= step_count + 1'b1;
                     if (({1'b0, step_count} + 1'b1) == {1'b0, n_lat}) begin
                        state <= DONE;
                        iss   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state <= MOMENT;
                     end
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign phase       = 3'(state);
   assign WE_p_mem    = we_q[0] & ~hold;
   assign WE_ux_mem   = we_q[1] & ~hold;
   assign WE_uy_mem   = we_q[2] & ~hold;
   assign WE_fin_mem  = we_q[3] & ~hold;
   assign WE_fout_mem = we_q[4] & ~hold;
   assign WE_feq_mem  = we_q[5] & ~hold;
   assign LD_EN_P     = ld_sr[RD_LAT-1] & ~hold;

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Self-checking bench for lbm_step_sequencer; reference model derives every output from
// the cycle index since start. Define LBM_STALL_EN to exercise the stall port as well.
module tb_lbm_step_sequencer;

   localparam int G    = 256;
   localparam int RL   = 1;
   localparam int PIPE = RL + 1;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        start;
   logic [15:0] n_steps;
   logic        busy, done;
   logic [2:0]  phase;
   logic [7:0]  rd_addr, wr_addr;
   logic        WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem;
   logic        select_fin, LD_EN_P;
   logic [15:0] step_count;
`ifdef LBM_STALL_EN
   logic        stall;
`endif

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   bit active = 1'b0;
   int r = 0;
   int nrun = 0;
   int last_steps = 0;

   lbm_step_sequencer #(.GRID_DIM(G), .RD_LAT(RL)) dut (
      .Clk(Clk), .Reset(Reset),
`ifdef LBM_STALL_EN
      .stall(stall),
`endif
      .start(start), .n_steps(n_steps), .busy(busy), .done(done), .phase(phase),
      .rd_addr(rd_addr), .wr_addr(wr_addr),
      .WE_p_mem(WE_p_mem), .WE_ux_mem(WE_ux_mem), .WE_uy_mem(WE_uy_mem),
      .WE_fin_mem(WE_fin_mem), .WE_fout_mem(WE_fout_mem), .WE_feq_mem(WE_feq_mem),
      .select_fin(select_fin), .LD_EN_P(LD_EN_P), .step_count(step_count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int done_idx(input int n);
      return G + 3 * n * (G + PIPE);
   endfunction

   function automatic void model_edge(input bit st, input logic [15:0] ns, input bit sl, input bit rs);
      if (rs) begin
         active     = 1'b0;
         last_steps = 0;
      end else if (!sl) begin
         if (!active) begin
            if (st) begin
               active = 1'b1;
               r      = 0;
               nrun   = int'(ns);
            end
         end else begin
            r++;
            if (r > done_idx(nrun)) begin
               active     = 1'b0;
               last_steps = nrun;
            end
         end
      end
   endfunction

   // Expected {busy,done,phase,we[feq,fout,fin,uy,ux,p],ld,sel,step,wr,rd} plus care mask
   function automatic void model_expect(input bit sl, output logic [44:0] ev, output logic [44:0] mv);
      logic       b = 1'b0, d = 1'b0, s = 1'b0, l = 1'b0, mw = 1'b0, mr = 1'b0;
      logic [2:0] ph = 3'd0;
      logic [5:0] we = 6'd0;
      logic [7:0] wa = 8'd0, ra = 8'd0;
      logic [15:0] stp;
      int k, j, p;
      stp = 16'(last_steps);
      if (active) begin
         if (r < G) begin
            b = 1'b1; ph = 3'd1; we = 6'b001111;
            wa = 8'(r); ra = 8'(r); mw = 1'b1; mr = 1'b1; stp = 16'd0;
         end else if (r < done_idx(nrun)) begin
            k = (r - G) / (G + PIPE);
            j = (r - G) % (G + PIPE);
            p = k % 3;
            b = 1'b1; ph = 3'(2 + p); stp = 16'(k / 3); s = (p == 2);
            if (j < G) begin ra = 8'(j); mr = 1'b1; end
            if (j >= PIPE && j < PIPE + G) begin
               we = (p == 0) ? 6'b000111 : (p == 1) ? 6'b110000 : 6'b001000;
               wa = 8'(j - PIPE); mw = 1'b1;
            end
            l = (p == 0) && (j >= RL) && (j < RL + G);
         end else begin
            d = 1'b1; ph = 3'd5; stp = 16'(nrun);
         end
      end
      if (sl) begin we = 6'd0; l = 1'b0; mw = 1'b0; end
      ev = {b, d, ph, we, l, s, stp, wa, ra};
      mv = {{29{1'b1}}, {8{mw}}, {8{mr}}};
   endfunction

   task automatic step_cycle(input bit st, input logic [15:0] ns, input bit sl, input bit rs);
      logic [44:0] ev, mv, ov;
      start = st; n_steps = ns; Reset = rs;
`ifdef LBM_STALL_EN
      stall = sl;
`endif
      @(posedge Clk);
      model_edge(st, ns, sl, rs);
      #1;
      model_expect(sl, ev, mv);
      ov = {busy, done, phase, WE_feq_mem, WE_fout_mem, WE_fin_mem, WE_uy_mem, WE_ux_mem,
            WE_p_mem, LD_EN_P, select_fin, step_count, wr_addr, rd_addr};
      check($sformatf("cyc r=%0d", r), 64'(ov & mv), 64'(ev & mv));
   endtask

   task automatic idle_gap();
      repeat ($urandom_range(1, 4)) step_cycle(1'b0, 16'($urandom), 1'b0, 1'b0);
   endtask

   task automatic do_run(input int n, input bit noisy, input int stall_at, input int stall_len);
      int busy_n = 0, done_n = 0, wep_n = 0, guard = 0, stalled = 0, d;
      bit st, sl;
      d = done_idx(n);
      step_cycle(1'b1, 16'(n), 1'b0, 1'b0);
      busy_n += int'(busy);
      wep_n  += int'(WE_p_mem);
      while (active && guard < 20000) begin
         st = noisy && (r + 2 < d) && ($urandom_range(0, 3) == 0);
         sl = (stall_len > 0) && (r == stall_at) && (stalled < stall_len);
         if (sl) stalled++;
         step_cycle(st, noisy ? 16'($urandom) : 16'(n), sl, 1'b0);
         busy_n += int'(busy);
         done_n += int'(done);
         wep_n  += int'(WE_p_mem);
         guard++;
      end
      check("run_bound", 64'(guard < 20000), 64'(1));
      check("busy_len", 64'(busy_n), 64'(d + stall_len));
      check("done_cnt", 64'(done_n), 64'(1));
      check("wep_cnt", 64'(wep_n), 64'(G + n * G));
      check("steps_end", 64'(step_count), 64'(n));
   endtask

   initial begin
      int guard;
      start = 1'b0; n_steps = '0; Reset = 1'b1;
`ifdef LBM_STALL_EN
      stall = 1'b0;
`endif
      step_cycle(1'b0, 16'd0, 1'b0, 1'b1);
      step_cycle(1'b0, 16'd0, 1'b0, 1'b1);
      check("rst_rd", 64'(rd_addr), 64'(0));
      check("rst_wr", 64'(wr_addr), 64'(0));
      step_cycle(1'b0, 16'd0, 1'b0, 1'b0);

      do_run(0, 1'b0, 0, 0);
      idle_gap();
      do_run(1, 1'b0, 0, 0);
      idle_gap();
      do_run(3, 1'b0, 0, 0);
      idle_gap();
      do_run(2, 1'b1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         idle_gap();
         do_run($urandom_range(1, 2), 1'b1, 0, 0);
      end

      // Abort in the first COLLIDE sweep at read address 100
      idle_gap();
      step_cycle(1'b1, 16'd2, 1'b0, 1'b0);
      guard = 0;
      while (active && r != G + (G + PIPE) + 100 && guard < 5000) begin
         step_cycle(1'b0, 16'($urandom), 1'b0, 1'b0);
         guard++;
      end
      check("abort_bound", 64'(guard < 5000), 64'(1));
      check("abort_point", 64'({phase, rd_addr}), 64'({3'd3, 8'd100}));
      step_cycle(1'b0, 16'd0, 1'b0, 1'b1);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_phase", 64'(phase), 64'(0));
      check("abort_we", 64'({WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem, LD_EN_P}), 64'(0));
      step_cycle(1'b0, 16'd0, 1'b0, 1'b0);
      idle_gap();
      do_run(1, 1'b0, 0, 0);

`ifdef LBM_STALL_EN
      idle_gap();
      do_run(1, 1'b0, G + 40, 5);
      idle_gap();
      do_run(1, 1'b0, G + 2 * (G + PIPE) + 7, 3);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
